// File: rtl/gb_vga_pkg.sv
// Shared definitions for the VGA screen sequencer.
// Contents: screen id constants, sequencer state enum, full-intensity level.
package gb_vga_pkg;

  localparam logic [2:0] SCR_WELCOME  = 3'd0;
  localparam logic [2:0] SCR_HOME     = 3'd1;
  localparam logic [2:0] SCR_CTRL     = 3'd2;
  localparam logic [2:0] SCR_SETTINGS = 3'd3;
  localparam logic [2:0] SCR_GAME     = 3'd4;

  localparam logic [3:0] INTENSITY_FULL = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_BLANK_OUT = 2'd1,
    ST_SWAP      = 2'd2,
    ST_FADE_IN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/vga_frame_edge.sv
// vsync synchroniser and frame-start detector.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   vsync_in    - asynchronous vSync of the selected screen controller
//   frame_tick  - registered one-cycle pulse per assertion edge of vsync_in
// Parameter VS_ACTIVE_LOW selects the asserting edge (1: falling, 0: rising).
module vga_frame_edge #(
  parameter int VS_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_in,
  output logic frame_tick
);

  localparam logic INACT = (VS_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;
  logic tick_q, tick_d;

  always_comb begin
    s1_d   = vsync_in;
    s2_d   = s1_q;
    hist_d = s2_q;
    tick_d = (s2_q != INACT) && (hist_q == INACT);
  end

  // All stages start at the inactive level so reset never fakes a frame start.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= INACT;
      s2_q   <= INACT;
      hist_q <= INACT;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
      tick_q <= tick_d;
    end
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/vga_screen_sequencer.sv
// Frame-synchronous screen-select controller for the VGA output muxes.
// A requested screen change is applied only on a frame boundary, with
// BLANK_FRAMES blanked frames before and after the swap.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   req_state   - UI FSM state code (4 bits); invalid codes map to homescreen
//   vsync_in    - vSync of the currently selected screen controller
//   screen_sel  - registered 3-bit select for the VGA muxes
//   blank       - 1 forces RGB to zero
//   intensity   - RGB scale factor (15 = full)
//   busy        - 1 while a switch is in progress
//   frame_tick  - one-cycle pulse per detected frame start
// Optional feature: define GB_VGA_FADE_EN for a stepped intensity ramp.
module vga_screen_sequencer
  import gb_vga_pkg::*;
#(
  parameter int NUM_SCREENS   = 5,
  parameter int BLANK_FRAMES  = 2,
  parameter int VS_ACTIVE_LOW = 1,
  parameter int FADE_STEP     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_state,
  input  logic       vsync_in,
  output logic [2:0] screen_sel,
  output logic       blank,
  output logic [3:0] intensity,
  output logic       busy,
  output logic       frame_tick
);

  if (NUM_SCREENS < 1 || NUM_SCREENS > 8) begin : g_bad_ns
    $error("NUM_SCREENS out of range");
  end
  if (BLANK_FRAMES < 1 || BLANK_FRAMES > 15) begin : g_bad_bf
    $error("BLANK_FRAMES out of range");
  end
  if (FADE_STEP < 1 || FADE_STEP > 15) begin : g_bad_fs
    $error("FADE_STEP out of range");
  end

  localparam logic [3:0] BF4 = 4'(BLANK_FRAMES);
  localparam logic [4:0] NS5 = 5'(NUM_SCREENS);

  logic       tick;
  logic [2:0] target;
  logic [3:0] cnt_inc;

  seq_state_e state_q, state_d;
  logic [3:0] frame_cnt_q, frame_cnt_d;
  logic [2:0] screen_sel_q, screen_sel_d;
  logic [2:0] pending_q, pending_d;

  vga_frame_edge #(.VS_ACTIVE_LOW(VS_ACTIVE_LOW)) u_frame_edge (
    .clk       (clk),
    .reset     (reset),
    .vsync_in  (vsync_in),
    .frame_tick(tick)
  );

  assign target  = ({1'b0, req_state} < NS5) ? req_state[2:0] : SCR_HOME;
  assign cnt_inc = (frame_cnt_q == 4'hF) ? 4'hF : frame_cnt_q + 4'd1;

`ifdef GB_VGA_FADE_EN
  localparam logic [3:0] STEP4 = 4'(FADE_STEP);
  logic [3:0] intensity_q, intensity_d;
  logic [3:0] int_dn, int_up;

  assign int_dn = (intensity_q > STEP4) ? intensity_q - STEP4 : 4'h0;
  assign int_up = (({1'b0, intensity_q} + {1'b0, STEP4}) >= {1'b0, INTENSITY_FULL})
                  ? INTENSITY_FULL : intensity_q + STEP4;
`endif

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    screen_sel_d = screen_sel_q;
    pending_d    = target;
`ifdef GB_VGA_FADE_EN
    intensity_d  = intensity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tick && (pending_q != screen_sel_q)) begin
          state_d     = ST_BLANK_OUT;
          frame_cnt_d = '0;
        end
      end
      ST_BLANK_OUT: begin
        if (tick) begin
          frame_cnt_d = cnt_inc;
`ifdef GB_VGA_FADE_EN
          intensity_d = int_dn;
          if ((int_dn == 4'h0) && (cnt_inc >= BF4)) state_d = ST_SWAP;
`else
          if (cnt_inc >= BF4) state_d = ST_SWAP;
`endif
        end
      end
      ST_SWAP: begin
        screen_sel_d = pending_q;
        frame_cnt_d  = '0;
        state_d      = ST_FADE_IN;
      end
      ST_FADE_IN: begin
        if (tick) begin
          frame_cnt_d = cnt_inc;
`ifdef GB_VGA_FADE_EN
          intensity_d = int_up;
          if ((int_up == INTENSITY_FULL) && (cnt_inc >= BF4)) state_d = ST_IDLE;
`else
          if (cnt_inc >= BF4) state_d = ST_IDLE;
`endif
        end
      end
      default: state_d = ST_FADE_IN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FADE_IN;
      frame_cnt_q  <= '0;
      screen_sel_q <= SCR_WELCOME;
      pending_q    <= SCR_WELCOME;
`ifdef GB_VGA_FADE_EN
      intensity_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      screen_sel_q <= screen_sel_d;
      pending_q    <= pending_d;
`ifdef GB_VGA_FADE_EN
      intensity_q  <= intensity_d;
`endif
    end
  end

  assign screen_sel = screen_sel_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_tick = tick;

`ifdef GB_VGA_FADE_EN
  // Blank only at zero intensity so the ramp itself stays visible.
  assign blank     = (intensity_q == 4'h0);
  assign intensity = intensity_q;
`else
  assign blank     = (state_q != ST_IDLE);
  assign intensity = blank ? 4'h0 : INTENSITY_FULL;
`endif

endmodule

// File: tb/tb_vga_screen_sequencer.sv
module tb_vga_screen_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_state;
  logic       vsync_in;
  logic [2:0] screen_sel;
  logic       blank;
  logic [3:0] intensity;
  logic       busy;
  logic       frame_tick;

  int total = 0;
  int bad   = 0;
  bit vs_run = 1'b1;
  int vs_cnt = 0;

  vga_screen_sequencer #(
    .NUM_SCREENS  (5),
    .BLANK_FRAMES (2),
    .VS_ACTIVE_LOW(1),
    .FADE_STEP    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_state (req_state),
    .vsync_in  (vsync_in),
    .screen_sel(screen_sel),
    .blank     (blank),
    .intensity (intensity),
    .busy      (busy),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // 40-cycle frames, vsync low for the first 4 cycles; held high when stopped.
  initial begin
    vsync_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (vs_run) begin
        vs_cnt   = (vs_cnt == 39) ? 0 : vs_cnt + 1;
        vsync_in = (vs_cnt < 4) ? 1'b0 : 1'b1;
      end else begin
        vsync_in = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s: got no frame_tick want tick within 200 cycles", name);
    end
  endtask

  task automatic do_switch(input logic [3:0] req, input logic [2:0] exp, input logic [2:0] old);
    @(negedge clk);
    req_state = req;
    wait_tick("sw_tick0");
    @(negedge clk);
    chk("sw_blank_out", {7'd0, blank}, 8'd1);
    chk("sw_busy", {7'd0, busy}, 8'd1);
    chk("sw_sel_held0", {5'd0, screen_sel}, {5'd0, old});
    wait_tick("sw_tick1");
    @(negedge clk);
    chk("sw_sel_held1", {5'd0, screen_sel}, {5'd0, old});
    wait_tick("sw_tick2");
    @(negedge clk);
    chk("sw_sel_swap", {5'd0, screen_sel}, {5'd0, old});
    @(negedge clk);
    chk("sw_sel_new", {5'd0, screen_sel}, {5'd0, exp});
    chk("sw_blank_fade", {7'd0, blank}, 8'd1);
    wait_tick("sw_tick3");
    @(negedge clk);
    chk("sw_blank_fade1", {7'd0, blank}, 8'd1);
    wait_tick("sw_tick4");
    @(negedge clk);
    chk("sw_blank_done", {7'd0, blank}, 8'd0);
    chk("sw_busy_done", {7'd0, busy}, 8'd0);
    chk("sw_int_full", {4'd0, intensity}, 8'h0F);
    chk("sw_sel_final", {5'd0, screen_sel}, {5'd0, exp});
  endtask

  typedef struct {
    logic [3:0] req;
    logic [2:0] exp_sel;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [2:0] cur;
    int ticks;
    bit busy_seen;

    vecs[0] = '{4'h1, 3'd1};
    vecs[1] = '{4'h2, 3'd2};
    vecs[2] = '{4'hA, 3'd1};
    vecs[3] = '{4'h4, 3'd4};
    vecs[4] = '{4'h3, 3'd3};
    vecs[5] = '{4'hF, 3'd1};
    vecs[6] = '{4'h0, 3'd0};

    // Reset with vsync running
    reset     = 1'b1;
    req_state = 4'h0;
    repeat (3) @(negedge clk);
    chk("rst_sel", {5'd0, screen_sel}, 8'd0);
    chk("rst_blank", {7'd0, blank}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd1);
    chk("rst_int", {4'd0, intensity}, 8'd0);
    chk("rst_tick", {7'd0, frame_tick}, 8'd0);
    reset = 1'b0;
    wait_tick("rst_tick1");
    @(negedge clk);
    chk("rst_blank1", {7'd0, blank}, 8'd1);
    wait_tick("rst_tick2");
    @(negedge clk);
    chk("rst_blank2", {7'd0, blank}, 8'd0);
    chk("rst_busy2", {7'd0, busy}, 8'd0);

    // Table-driven switches, including invalid-code fallback
    cur = 3'd0;
    for (int i = 0; i < 7; i++) begin
      do_switch(vecs[i].req, vecs[i].exp_sel, cur);
      cur = vecs[i].exp_sel;
    end

    // Last request wins during BLANK_OUT: 0 -> 1, then 2, then 3
    @(negedge clk);
    req_state = 4'h1;
    wait_tick("lw_tick0");
    @(negedge clk);
    chk("lw_busy", {7'd0, busy}, 8'd1);
    req_state = 4'h2;
    repeat (5) @(negedge clk);
    req_state = 4'h3;
    wait_tick("lw_tick1");
    wait_tick("lw_tick2");
    @(negedge clk);
    @(negedge clk);
    chk("lw_sel", {5'd0, screen_sel}, 8'd3);
    wait_tick("lw_tick3");
    wait_tick("lw_tick4");
    @(negedge clk);
    chk("lw_idle", {7'd0, busy}, 8'd0);
    wait_tick("lw_tick5");
    @(negedge clk);
    chk("lw_no_resw", {7'd0, busy}, 8'd0);
    chk("lw_sel_kept", {5'd0, screen_sel}, 8'd3);

    // Revert within one frame while idle: 3 -> 2 -> 3
    wait_tick("rv_tick0");
    @(negedge clk);
    req_state = 4'h2;
    repeat (5) @(negedge clk);
    req_state = 4'h3;
    busy_seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (busy) busy_seen = 1'b1;
    end
    chk("rv_busy", {7'd0, busy_seen}, 8'd0);
    chk("rv_sel", {5'd0, screen_sel}, 8'd3);

    // Reset mid-BLANK_OUT, then stuck vsync
    @(negedge clk);
    req_state = 4'h1;
    wait_tick("rm_tick0");
    @(negedge clk);
    chk("rm_busy", {7'd0, busy}, 8'd1);
    vs_run = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rm_sel", {5'd0, screen_sel}, 8'd0);
    chk("rm_blank", {7'd0, blank}, 8'd1);
    ticks = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (frame_tick) ticks++;
    end
    chk("stk_ticks", 8'(ticks), 8'd0);
    chk("stk_blank", {7'd0, blank}, 8'd1);
    chk("stk_busy", {7'd0, busy}, 8'd1);
    chk("stk_sel", {5'd0, screen_sel}, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
